// File: rtl/sdram_fill_ctrl.sv
// Fills MAX_COUNT SDRAM words at base_addr with the pattern SEED+idx.
// Defining SDRAM_FILL_READBACK_EN adds a pipelined read-back check of the filled block.
module sdram_fill_ctrl #(
  parameter int unsigned MAX_COUNT = 200,
  parameter logic [15:0] SEED      = 16'h0000
) (
  input  logic        clock_hf,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] base_addr,
  output logic [21:0] sdram_controller_address,
  output logic [1:0]  sdram_controller_byteenable_n,
  output logic        sdram_controller_chipselect,
  output logic [15:0] sdram_controller_writedata,
  output logic        sdram_controller_write_n,
  output logic        sdram_controller_read_n,
  input  logic [15:0] sdram_controller_readdata,
  input  logic        sdram_controller_readdatavalid,
  input  logic        sdram_controller_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_count
);

  // Handshake: a transfer is accepted on any cycle where write_n (or read_n) is
  // low and waitrequest is low; while waitrequest is high, command, address and
  // data stay unchanged.
  localparam logic [21:0] LAST_IDX = 22'(MAX_COUNT - 1);

`ifdef SDRAM_FILL_READBACK_EN
  localparam logic [21:0] NUM_WORDS = 22'(MAX_COUNT);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [21:0] idx_q, idx_d;
  logic [21:0] base_q, base_d;

`ifdef SDRAM_FILL_READBACK_EN
  logic [21:0] rsp_q, rsp_d;
  logic [15:0] err_count_q, err_count_d;
  logic        error_q, error_d;
`endif

  always_ff @(posedge clock_hf or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
`ifdef SDRAM_FILL_READBACK_EN
      rsp_q       <= '0;
      err_count_q <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
`ifdef SDRAM_FILL_READBACK_EN
      rsp_q       <= rsp_d;
      err_count_q <= err_count_d;
      error_q     <= error_d;
`endif
    end
  end

  // Command outputs decode from state_q only, so an async reset drops them at once.
  always_comb begin
    state_d                    = state_q;
    idx_d                      = idx_q;
    base_d                     = base_q;
    sdram_controller_address   = '0;
    sdram_controller_writedata = '0;
    sdram_controller_write_n   = 1'b1;
    sdram_controller_read_n    = 1'b1;
    busy                       = 1'b0;
    done                       = 1'b0;
`ifdef SDRAM_FILL_READBACK_EN
    rsp_d                      = rsp_q;
    err_count_d                = err_count_q;
    error_d                    = error_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          state_d = S_WRITE;
`ifdef SDRAM_FILL_READBACK_EN
          err_count_d = '0;
          error_d     = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        busy                       = 1'b1;
        sdram_controller_write_n   = 1'b0;
        sdram_controller_address   = base_q + idx_q;
        sdram_controller_writedata = SEED + idx_q[15:0];
        if (!sdram_controller_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef SDRAM_FILL_READBACK_EN
            rsp_d   = '0;
            state_d = S_READ;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + 22'd1;
          end
        end
      end
`ifdef SDRAM_FILL_READBACK_EN
      S_READ: begin
        busy = 1'b1;
        // Issue side and response side run independently; idx stops at NUM_WORDS.
        if (idx_q != NUM_WORDS) begin
          sdram_controller_read_n  = 1'b0;
          sdram_controller_address = base_q + idx_q;
          if (!sdram_controller_waitrequest) idx_d = idx_q + 22'd1;
        end
        if (sdram_controller_readdatavalid) begin
          if (sdram_controller_readdata != (SEED + rsp_q[15:0])) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
          rsp_d = rsp_q + 22'd1;
          if (rsp_q == LAST_IDX) state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign sdram_controller_byteenable_n = 2'b00;
  assign sdram_controller_chipselect   = ~sdram_controller_write_n | ~sdram_controller_read_n;

`ifdef SDRAM_FILL_READBACK_EN
  assign error     = error_q;
  assign err_count = err_count_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{sdram_controller_readdata, sdram_controller_readdatavalid};
  assign error      = 1'b0;
  assign err_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_fill_ctrl.sv
// Self-checking bench for sdram_fill_ctrl: table-driven runs, hand-written reset/DONE
// sequences and randomized runs scored against a word-list model of the fill.
module tb_sdram_fill_ctrl;

  localparam int unsigned MAX_COUNT = 4;
  localparam logic [15:0] SEED      = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [21:0] base_addr;
  logic [21:0] address;
  logic [1:0]  byteenable_n;
  logic        chipselect;
  logic [15:0] writedata;
  logic        write_n;
  logic        read_n;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_count;

  sdram_fill_ctrl #(.MAX_COUNT(MAX_COUNT), .SEED(SEED)) dut (
    .clock_hf                      (clk),
    .reset                         (rst_n),
    .start                         (start),
    .base_addr                     (base_addr),
    .sdram_controller_address      (address),
    .sdram_controller_byteenable_n (byteenable_n),
    .sdram_controller_chipselect   (chipselect),
    .sdram_controller_writedata    (writedata),
    .sdram_controller_write_n      (write_n),
    .sdram_controller_read_n       (read_n),
    .sdram_controller_readdata     (readdata),
    .sdram_controller_readdatavalid(readdatavalid),
    .sdram_controller_waitrequest  (waitrequest),
    .busy                          (busy),
    .done                          (done),
    .error                         (error),
    .err_count                     (err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: expected writes {addr, data} ----------------
  logic [37:0] exp_q[$];
  bit          hold_v = 1'b0;
  logic [21:0] hold_addr;
  logic [15:0] hold_data;
  bit          done_next = 1'b0;
  int          corrupt_word = -1;
  logic [15:0] mem[int];

  // Model of one run: word i goes to (base+i) mod 2^22 carrying (SEED+i) mod 2^16.
  task automatic push_run(input logic [21:0] base);
    logic [21:0] a;
    logic [15:0] d;
    for (int i = 0; i < int'(MAX_COUNT); i++) begin
      a = base + 22'(i);
      d = SEED + 16'(i);
      exp_q.push_back({a, d});
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_v    = 1'b0;
      done_next = 1'b0;
    end else begin
      chk("cmd_rules", 32'({chipselect == (~write_n | ~read_n), ~(~write_n & ~read_n),
                            (!chipselect || byteenable_n == 2'b00)}), 32'd7);
      if (done_next) begin
        done_next = 1'b0;
        chk("write_n_after_last", 32'(write_n), 32'd1);
`ifndef SDRAM_FILL_READBACK_EN
        chk("done_busy_after_last", 32'({done, busy}), 32'b10);
`endif
      end
      if (!write_n) begin
        if (hold_v) begin
          chk("hold_addr", 32'(address), 32'(hold_addr));
          chk("hold_data", 32'(writedata), 32'(hold_data));
        end
        if (waitrequest) begin
          hold_v    = 1'b1;
          hold_addr = address;
          hold_data = writedata;
        end else begin
          hold_v = 1'b0;
          mem[int'(address)] = writedata;
          chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            logic [37:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(address), 32'(e[37:16]));
            chk("wr_data", 32'(writedata), 32'(e[15:0]));
            if (exp_q.size() == 0) done_next = 1'b1;
          end
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

`ifdef SDRAM_FILL_READBACK_EN
  // Read responder: returns stored words with a fixed 2-cycle latency.
  typedef struct {int due; logic [15:0] data;} rsp_t;
  rsp_t rsp_pipe[$];
  int   cyc_g = 0;
  int   rd_issue = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) rsp_pipe.delete();
    else if (!read_n && !waitrequest) begin
      rsp_t r;
      r.due  = cyc_g + 2;
      r.data = (rd_issue == corrupt_word) ? 16'hBEEF :
               (mem.exists(int'(address)) ? mem[int'(address)] : 16'h0000);
      rsp_pipe.push_back(r);
      rd_issue++;
    end
    @(posedge clk);
    #1;
    readdatavalid = 1'b0;
    if (rsp_pipe.size() != 0 && rsp_pipe[0].due == cyc_g) begin
      rsp_t r;
      r = rsp_pipe.pop_front();
      readdatavalid = 1'b1;
      readdata      = r.data;
    end
  end
`endif

  // ---------------- driver ----------------
  // Entered and left at posedge+1. ww/wc: hold waitrequest on write word ww for wc cycles.
  task automatic run_vec(input logic [21:0] base, input int ww, input int wc, input bit rnd,
                         output int wcyc, output logic [21:0] last_addr);
    int widx, wcnt, n;
    bit fin;
    push_run(base);
`ifdef SDRAM_FILL_READBACK_EN
    rd_issue = 0;
`endif
    start       = 1'b1;
    base_addr   = base;
    waitrequest = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 22'($urandom);
    widx = 0; wcnt = 0; wcyc = 0; n = 0; fin = 1'b0; last_addr = '0;
    while (!fin && n < 300) begin
      waitrequest = rnd ? ($urandom_range(0, 2) == 0) : (widx == ww && wcnt < wc);
      start       = rnd && busy && ($urandom_range(0, 3) == 0);
      if (rnd) base_addr = 22'($urandom);
      @(negedge clk);
      if (n == 0) begin
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
      end
      if (!write_n) begin
        wcyc++;
        if (waitrequest) wcnt++;
        else begin
          last_addr = address;
          widx++;
          wcnt = 0;
        end
      end
      fin = done;
      n++;
      @(posedge clk);
      #1;
    end
    start       = 1'b0;
    waitrequest = 1'b0;
    chk("run_finished", 32'(fin), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`ifdef SDRAM_FILL_READBACK_EN
    chk("error", 32'(error), (corrupt_word >= 0 && corrupt_word < int'(MAX_COUNT)) ? 32'd1 : 32'd0);
    chk("err_count", 32'(err_count), (corrupt_word >= 0 && corrupt_word < int'(MAX_COUNT)) ? 32'd1 : 32'd0);
`endif
  endtask

  // ---------------- table of vectors ----------------
  typedef struct {
    logic [21:0] base;
    int          wait_word;
    int          wait_cycles;
    int          exp_write_cycles;
    logic [21:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          wcyc;
    logic [21:0] la;
    logic [21:0] rb;

    vecs[0] = '{22'd10,       -1, 0, 4, 22'd13};
    vecs[1] = '{22'd10,        2, 3, 7, 22'd13};
    vecs[2] = '{22'h3FFFFE,   -1, 0, 4, 22'h000001};
    vecs[3] = '{22'h3FFFFF,    0, 2, 6, 22'h000002};
    vecs[4] = '{22'h1ABCDE,    3, 1, 5, 22'h1ABCE1};

    rst_n         = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    waitrequest   = 1'b0;
    readdata      = '0;
    readdatavalid = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_writedata", 32'(writedata), 32'd0);
    chk("rst_cs", 32'(chipselect), 32'd0);
    chk("rst_write_n", 32'(write_n), 32'd1);
    chk("rst_read_n", 32'(read_n), 32'd1);
    chk("rst_be_n", 32'(byteenable_n), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_err", 32'({error, err_count}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Stray response in IDLE must be ignored
    readdatavalid = 1'b1;
    readdata      = 16'h1234;
    @(posedge clk);
    #1;
    readdatavalid = 1'b0;
    chk("idle_after_rst", 32'({busy, done, error, write_n}), 32'b0001);

    // Table-driven runs (first from IDLE, later ones start from DONE)
    for (int v = 0; v < 5; v++) begin
      run_vec(vecs[v].base, vecs[v].wait_word, vecs[v].wait_cycles, 1'b0, wcyc, la);
      chk($sformatf("vec%0d_write_cycles", v), 32'(wcyc), 32'(vecs[v].exp_write_cycles));
      chk($sformatf("vec%0d_last_addr", v), 32'(la), 32'(vecs[v].exp_last_addr));
    end

    // DONE is sticky and idle on the bus
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_sticky", 32'({done, busy, chipselect}), 32'b100);
    @(posedge clk);
    #1;

    // Reset in the middle of WRITE at idx 2
    push_run(22'd10);
    start     = 1'b1;
    base_addr = 22'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_addr", 32'(address), 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_write_n", 32'(write_n), 32'd1);
    chk("midrst_cs", 32'(chipselect), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(address), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(22'd10, -1, 0, 1'b0, wcyc, la);
    chk("restart_write_cycles", 32'(wcyc), 32'd4);
    chk("restart_last_addr", 32'(la), 32'd13);

`ifdef SDRAM_FILL_READBACK_EN
    corrupt_word = 1;
    run_vec(22'd10, -1, 0, 1'b0, wcyc, la);
    chk("corrupt_done", 32'(done), 32'd1);
    corrupt_word = -1;
`endif

    // Randomized runs: random waitrequest, base_addr noise, start pulses while busy
    for (int r = 0; r < 20; r++) begin
      rb = 22'($urandom);
      run_vec(rb, -1, 0, 1'b1, wcyc, la);
      chk("rnd_last_addr", 32'(la), 32'(rb + 22'(MAX_COUNT - 1)));
      chk("rnd_min_cycles", 32'(wcyc >= int'(MAX_COUNT)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
